// File: rtl/online_result_collector_div.sv
// Collects the MSD-first signed-digit quotient stream, drops the online-delay digits and
// converts on the fly (Q/QM) into a two's-complement result. Optional macro: RES_ROUND_EN.
module online_result_collector_div #(
  parameter int unsigned UNROLLING    = 64,
  parameter int unsigned ONLINE_DELAY = 2,
  parameter int unsigned RES_WIDTH    = UNROLLING + 1
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic                 start,
  input  logic                 digit_valid,
  input  logic [1:0]           digit_in,
  input  logic                 res_ready,
  output logic [RES_WIDTH-1:0] result,
  output logic                 res_valid,
  output logic                 busy,
  output logic [10:0]          digit_cnt,
  output logic                 overflow_err
);

  localparam int unsigned CNT_W = 11;
`ifdef RES_ROUND_EN
  localparam int unsigned QW   = RES_WIDTH + 1;
  localparam int unsigned NDIG = UNROLLING + 1;
`else
  localparam int unsigned QW   = RES_WIDTH;
  localparam int unsigned NDIG = UNROLLING;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [QW-1:0]      q_q, q_d;
  logic [QW-1:0]      qm_q, qm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   skip_q, skip_d;
  logic [RES_WIDTH-1:0] res_q, res_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;

  // Final conversion of the collected Q register into the presented result.
  function automatic logic [RES_WIDTH-1:0] conv(input logic [QW-1:0] q);
`ifdef RES_ROUND_EN
    logic [QW-1:0] sum;
    sum = q + QW'(1);
    if (!q[QW-1] && sum[QW-1]) conv = {1'b0, {(RES_WIDTH-1){1'b1}}};
    else                       conv = sum[QW-1:1];
`else
    conv = q;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
      skip_q  <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    res_d   = res_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q;

    // start has priority everywhere and swallows a coincident digit.
    if (start) begin
      q_d     = '0;
      qm_d    = '1;
      cnt_d   = '0;
      skip_d  = '0;
      vld_d   = 1'b0;
      state_d = (ONLINE_DELAY == 0) ? COLLECT : SKIP;
    end else begin
      case (state_q)
        SKIP: begin
          if (digit_valid) begin
            skip_d = skip_q + CNT_W'(1);
            if (skip_d == CNT_W'(ONLINE_DELAY)) state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (digit_valid) begin
            if (digit_in == 2'b10) begin
              q_d  = {q_q[QW-2:0], 1'b1};
              qm_d = {q_q[QW-2:0], 1'b0};
            end else if (digit_in == 2'b01) begin
              q_d  = {qm_q[QW-2:0], 1'b1};
              qm_d = {qm_q[QW-2:0], 1'b0};
            end else begin
              q_d  = {q_q[QW-2:0], 1'b0};
              qm_d = {qm_q[QW-2:0], 1'b1};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(NDIG)) begin
              state_d = HOLD;
              res_d   = conv(q_d);
              vld_d   = 1'b1;
            end
          end
        end
        HOLD: begin
          if (digit_valid) ovf_d = 1'b1;
          if (vld_q && res_ready) begin
            state_d = IDLE;
            vld_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign result       = res_q;
  assign res_valid    = vld_q;
  assign busy         = busy_q;
  assign digit_cnt    = cnt_q;
  assign overflow_err = ovf_q;

endmodule

// File: doc/online_result_collector_div.md
Name: online_result_collector_div

Overview:
- Downstream stage of the online-division computation controller.
- Consumes the MSD-first signed-digit quotient stream produced under that controller's pacing.
- Discards the online-delay leading digits and performs on-the-fly conversion (Q/QM registers) into a parallel two's-complement result.
- Presents the result to the Newton iteration datapath through a valid/ready handshake.

Parameters:
- UNROLLING, 64, number of quotient digits kept per result vector
- ONLINE_DELAY, 2, leading valid digits discarded at the start of each vector
- RES_WIDTH, UNROLLING+1, result width: sign bit plus UNROLLING fractional bits (value = result * 2^-UNROLLING)

Ports:
- clk  input  1  sole clock; all state updates on its rising edge
- asyn_reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk only
- start  input  1  one-cycle pulse; begins a new vector
- digit_valid  input  1  digit_in is meaningful this cycle
- digit_in  input  2  signed digit {p,n}: 2'b10=+1, 2'b01=-1, 2'b00 and 2'b11=0
- res_ready  input  1  consumer accepts result
- result  output  RES_WIDTH  converted quotient, two's complement
- res_valid  output  1  result holds a complete vector
- busy  output  1  high in SKIP/COLLECT/HOLD
- digit_cnt  output  11  digits collected in the current vector (excludes skipped digits)
- overflow_err  output  1  sticky; a digit arrived while in HOLD

Behaviour:
- Reset: state=IDLE; Q=0; QM=all ones; result=0; res_valid=0; busy=0; digit_cnt=0; overflow_err=0. Reset overrides all other inputs. Reset mid-vector abandons the vector with no partial output.
- State machine:
  - IDLE: start -> SKIP, with Q=0, QM=all ones, digit_cnt=0, skip counter=0. If ONLINE_DELAY=0, go directly to COLLECT.
  - SKIP: each valid digit increments the skip counter; the digit is dropped. On the ONLINE_DELAY-th valid digit -> COLLECT.
  - COLLECT: each valid digit updates Q/QM and increments digit_cnt. Update rules, shift-left-append within RES_WIDTH:
    - q=+1: Q<=Q:1, QM<=Q:0
    - q=0: Q<=Q:0, QM<=QM:1
    - q=-1: Q<=QM:1, QM<=QM:0
    - On the UNROLLING-th digit -> HOLD. result is registered from the updated Q; res_valid rises the cycle after the last digit is sampled (1-cycle latency).
  - HOLD: res_valid=1 and result stable. res_valid&res_ready -> IDLE, with res_valid low next cycle. A valid digit in HOLD is dropped and sets overflow_err.
- start in any non-IDLE state restarts the vector (same as start from IDLE). An unconsumed result in HOLD is discarded; overflow_err is unchanged.
- digit_valid with start in the same cycle: the digit is ignored.
- digit_valid=0 cycles are stalls; no state changes.
- Gaps between digits of any length are legal.
- Q and QM never overflow: |value| <= 1-2^-UNROLLING.
- overflow_err clears only on reset.

Optional Feature:
- Macro RES_ROUND_EN.
- Defined:
  - COLLECT takes UNROLLING+1 digits (one guard digit).
  - Q/QM are RES_WIDTH+1 bits wide.
  - result = (Q+1)>>>1, i.e. round half up.
  - If rounding overflows positive, result saturates to 0 followed by all ones.
  - digit_cnt counts the guard digit.
- Undefined: truncation by exactly UNROLLING digits, no guard digit, no rounding logic.

Test Plan (UNROLLING=4, ONLINE_DELAY=2, RES_WIDTH=5):
- Reset in cycle 0, hold 2 cycles -> result=0, res_valid=0, busy=0, overflow_err=0.
- start; digits -1,+1 (skipped) then +1,0,-1,+1 with res_ready=1 -> result=5'b00111 (7), res_valid high one cycle after last digit, then IDLE.
- start; skip 2; digits -1,-1,-1,-1 with gaps of 3 idle cycles; res_ready held low 5 cycles -> result=5'b10001 (-15), res_valid stays high until res_ready, digit_cnt=4.
- In HOLD, send one valid digit -> overflow_err=1 (sticky), result unchanged; then start mid-SKIP of the next vector -> vector restarts, digit_cnt=0.
- start; skip 2; digits 0,+1; asyn_reset for 1 cycle; then full vector 0,+1,-1,0 -> result=5'b00010 (2), with no residue from the aborted vector.
- RES_ROUND_EN: digits +1,0,-1,+1,+1 -> result=5'b01000 (8); digits +1,+1,+1,+1,+1 -> saturates to 5'b01111.
